div_uint_seq: RTL

//  Sequential unsigned integer divider: the inverse of the 4-bit unsigned multiply datapath.

---
 rtl/div_uint_seq_if.sv | 27 ++
 rtl/div_uint_seq.sv | 102 ++++++++++
 2 files changed

// File: rtl/div_uint_seq_if.sv
// Valid/ready handshake bundle for the sequential unsigned divider:
// operand channel (in_*, A, B) and result channel (out_*, Q, R, div_by_zero).
interface div_uint_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  // Requester side: supplies operands and consumes results.
  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Q, R, div_by_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Q, R, div_by_zero
  );
endinterface

// File: rtl/div_uint_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first,
// with valid/ready handshakes on operands and results.
module div_uint_seq #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  div_uint_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  // Dividend shifts out of the top while quotient bits shift into the bottom,
  // so after WIDTH iterations this register holds the quotient.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] rem;

  logic [WIDTH:0]   rem_shift;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] a_next;

  // One restoring step. A successful subtraction always leaves a value below
  // B, so the difference fits in WIDTH bits and the extra bit is only needed
  // for the comparison.
  always_comb begin
    rem_shift = {rem, a_sh[WIDTH-1]};
    qbit      = (rem_shift >= {1'b0, b_reg});
    rem_next  = qbit ? (rem_shift[WIDTH-1:0] - b_reg) : rem_shift[WIDTH-1:0];
    a_next    = {a_sh[WIDTH-2:0], qbit};
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values; blocking here would create order races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      a_sh            <= '0;
      b_reg           <= '0;
      rem             <= '0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.Q           <= '0;
      bus.R           <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh         <= bus.A;
            b_reg        <= bus.B;
            rem          <= '0;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            state        <= RUN;
          end
        end

        RUN: begin
          a_sh <= a_next;
          rem  <= rem_next;
          cnt  <= cnt + 1'b1;
          // Results are published only here, so Q/R stay at the previous
          // answer throughout RUN.
          if (cnt == LAST) begin
            bus.Q           <= a_next;
            bus.R           <= rem_next;
            bus.div_by_zero <= (b_reg == '0);
            bus.out_valid   <= 1'b1;
            state           <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
